// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   mdu_op_e : operation encoding carried on the op port
//   mdu_st_e : controller states
//   ITER_LAST: counter value of the final CALC iteration
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } mdu_st_e;

  localparam logic [4:0] ITER_LAST = 5'd31;

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of the multiply/divide datapath.
//   work_i   : 2W-bit working register ({acc, mplier} or {rem, quot})
//   opnd_i   : multiplicand (multiply) or divisor (divide), unsigned magnitude
//   is_div_i : 1 selects a restoring-divide step, 0 a shift-add step
//   work_o   : working register after this iteration
module mdu_step #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] work_i,
  input  logic [W-1:0]   opnd_i,
  input  logic           is_div_i,
  output logic [2*W-1:0] work_o
);

  logic [W:0]   sum;
  logic [W:0]   sh;
  logic         ge;
  logic [W-1:0] rem_sub;

  always_comb begin
    // Multiply: add multiplicand on mplier LSB, then shift the whole
    // register right with the carry entering at the top.
    sum     = {1'b0, work_i[2*W-1:W]} + (work_i[0] ? {1'b0, opnd_i} : {(W+1){1'b0}});
    // Divide: the shifted remainder needs W+1 bits because the divisor
    // may exceed 2^(W-1); after the trial subtract it fits in W bits again.
    sh      = work_i[2*W-1:W-1];
    ge      = (sh >= {1'b0, opnd_i});
    rem_sub = sh[W-1:0] - opnd_i;
    if (is_div_i) begin
      if (ge) work_o = {rem_sub,   work_i[W-2:0], 1'b1};
      else    work_o = {sh[W-1:0], work_i[W-2:0], 1'b0};
    end else begin
      work_o = {sum, work_i[W-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MIPS multiply/divide unit (mult, multu, div, divu).
// Operates on magnitudes for 32 iterations, then applies signs in FIXUP.
//   clk, rst     : clock, synchronous active-high reset
//   start, op    : request (sampled in IDLE) and operation code
//   data1, data2 : multiplicand/dividend, multiplier/divisor
//   busy         : high in CALC and FIXUP
//   done         : one-cycle completion pulse
//   hi, lo       : product[63:32]/remainder, product[31:0]/quotient
//   div_by_zero  : set when the last completed op divided by zero
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  mdu_st_e          state_q;
  logic [4:0]       cnt_q;
  logic             is_div_q;
  logic             neg_res_q;   // product / quotient must be negated
  logic             neg_rem_q;   // remainder takes the dividend's (negative) sign
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [2*WIDTH-1:0] work_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] work_step;

  logic             is_div_in;
  logic             a_neg;
  logic             b_neg;
  logic             zero_div;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic [WIDTH-1:0] fix_hi_d;
  logic [WIDTH-1:0] fix_lo_d;

  function automatic logic [2*WIDTH-1:0] neg2w(input logic [2*WIDTH-1:0] x);
    return -x;
  endfunction

  // Operand conditioning at accept: signed ops work on magnitudes.
  always_comb begin
    is_div_in = op[1];
    a_neg     = ~op[0] & data1[WIDTH-1];
    b_neg     = ~op[0] & data2[WIDTH-1];
    abs1      = a_neg ? -data1 : data1;
    abs2      = b_neg ? -data2 : data2;
    zero_div  = is_div_in & (data2 == {WIDTH{1'b0}});
  end

  mdu_step #(.W(WIDTH)) u_step (
    .work_i   (work_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .work_o   (work_step)
  );

  // Sign correction applied on the FIXUP -> DONE edge.
  always_comb begin
    fix_hi_d = work_q[2*WIDTH-1:WIDTH];
    fix_lo_d = work_q[WIDTH-1:0];
    if (is_div_q) begin
      if (neg_res_q) fix_lo_d = -work_q[WIDTH-1:0];
      if (neg_rem_q) fix_hi_d = -work_q[2*WIDTH-1:WIDTH];
    end else if (neg_res_q) begin
      {fix_hi_d, fix_lo_d} = neg2w(work_q);
    end
  end

  // Controller and architectural result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            is_div_q  <= is_div_in;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            cnt_q     <= 5'd0;
            if (zero_div) begin
              // Divide by zero skips the iteration entirely.
              hi_q    <= data1;
              lo_q    <= {WIDTH{1'b1}};
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == ITER_LAST) state_q <= FIXUP;
        end
        FIXUP: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          dbz_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; the controller gates their use.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      opnd_q <= is_div_in ? abs2 : abs1;
      work_q <= {{WIDTH{1'b0}}, (is_div_in ? abs1 : abs2)};
    end else if (state_q == CALC) begin
      work_q <= work_step;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .data1       (data1),
    .data2       (data2),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {div_by_zero, hi, lo} from plain MIPS arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p, qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = sa * sb; return {1'b0, p}; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        qq = q; rr = r;
        return {1'b0, rr[31:0], qq[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Issue one op and check latency, busy, and results.
  // poke_at > 0 pulses start with other operands that many edges into CALC.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int poke_at);
    logic [64:0] exp;
    int          n;
    bit          dz;
    exp = model(o, a, b);
    dz  = exp[64];
    @(negedge clk);
    start = 1'b1; op = o; data1 = a; data2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_after_accept"}, busy, !dz);
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (poke_at > 0 && n == poke_at) begin
        start = 1'b1; op = ~o; data1 = $urandom; data2 = $urandom;
      end
    end
    start = 1'b0;
    check({tag, ".latency"}, n, dz ? 0 : 33);
    check({tag, ".hi"}, hi, exp[63:32]);
    check({tag, ".lo"}, lo, exp[31:0]);
    check({tag, ".dbz"}, div_by_zero, dz);
    check({tag, ".busy_at_done"}, busy, 0);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, done, 0);
    if (poke_at > 0) begin
      // A start seen mid-CALC must not have queued a second op.
      @(posedge clk); #1;
      check({tag, ".no_queue"}, {busy, done}, 0);
    end
  endtask

  initial begin
    logic [64:0] exp;
    int          edges, ndone;
    int          done_at[3];
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = 2'b00; data1 = '0; data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.outputs", {busy, done, div_by_zero, hi, lo}, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max.const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op("mult_neg", 2'b00, 32'hFFFF_FFF9, 32'd3, 0);
    check("mult_neg.const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    check("mult_min.const", {hi, lo}, 64'h4000_0000_0000_0000);
    do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg.const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("divu_100_7", 2'b11, 32'd100, 32'd7, 0);
    check("divu_100_7.const", {hi, lo}, {32'd2, 32'd14});
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf.const", {hi, lo}, {32'd0, 32'h8000_0000});
    do_op("div_zero", 2'b10, 32'h1234, 32'd0, 0);
    check("div_zero.const", {div_by_zero, hi, lo}, {1'b1, 32'h1234, 32'hFFFF_FFFF});
    do_op("divu_9_3", 2'b11, 32'd9, 32'd3, 0);
    check("divu_9_3.const", {div_by_zero, hi, lo}, {1'b0, 32'd0, 32'd3});
    do_op("poke_mid_calc", 2'b00, 32'd12345, 32'hFFFF_0001, 5);

    // start held high: one accept per 35 cycles.
    exp = model(2'b01, 32'd1000, 32'd777);
    @(negedge clk);
    start = 1'b1; op = 2'b01; data1 = 32'd1000; data2 = 32'd777;
    edges = 0; ndone = 0;
    while (ndone < 3 && edges < 150) begin
      @(posedge clk); #1;
      if (done) begin
        done_at[ndone] = edges;
        check("held.hi", hi, exp[63:32]);
        check("held.lo", lo, exp[31:0]);
        ndone++;
      end
      edges++;
    end
    start = 1'b0;
    check("held.count", ndone, 3);
    if (ndone == 3) begin
      check("held.first", done_at[0], 33);
      check("held.period1", done_at[1] - done_at[0], 35);
      check("held.period2", done_at[2] - done_at[1], 35);
    end
    repeat (3) @(posedge clk);

    // Reset in the middle of CALC discards the op and clears outputs.
    @(negedge clk);
    start = 1'b1; op = 2'b01; data1 = 32'hDEAD_BEEF; data2 = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid.outputs", {busy, done, div_by_zero, hi, lo}, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid.quiet", {busy, done, hi, lo}, 0);
    do_op("after_rst_mult", 2'b00, 32'd6, 32'd7, 0);
    check("after_rst_mult.const", {hi, lo}, 64'd42);

    // Randomized ops, biased toward edge operands.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        2: ra = $urandom_range(0, 20);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'h8000_0000;
        3: rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      do_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
